fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the control unit.
- Owns the fetch PC and drives a single-outstanding request/acknowledge handshake to instruction memory.
- Buffers returned words in a small in-order queue and presents the head instruction, pre-split into op/cond/funct/rd fields, to control.
- Accepts the branch redirect (pc_src plus target) and flushes stale instructions.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address issued first after reset.
- QDEPTH, 2, instruction queue entries; legal range 2..4.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  fetch request; held until imem_ack.
- imem_addr  out  32  word-aligned fetch address; stable while imem_req=1.
- imem_ack  in  1  memory returns imem_rdata this cycle; completes the request.
- imem_rdata  in  32  instruction word; sampled only when imem_ack=1.
- pc_src  in  1  redirect request from control; taken branch or write to R15.
- pc_target  in  32  redirect address; sampled when pc_src=1.
- stall  in  1  consumer not ready; head is not dequeued.
- instr_valid  out  1  head entry valid.
- instr  out  32  head instruction word.
- instr_pc  out  32  address of the head instruction.
- pc_plus8  out  32  instr_pc+8 (R15 read value).
- op  out  2  instr[27:26].
- cond  out  4  instr[31:28].
- funct  out  6  instr[25:20].
- rd  out  4  instr[15:12].

Behaviour:
- Reset (async, rst_n=0):
  - fpc=RESET_PC; queue empty; outstanding=0; drop=0.
  - imem_req=0, imem_addr=RESET_PC, instr_valid=0.
  - instr, instr_pc, pc_plus8, op, cond, funct and rd are all 0.
- Invalid head: while instr_valid=0, instr and all field outputs read 0. instr_pc and pc_plus8 read 0.
- Issue:
  - imem_req rises on a clock edge when outstanding=0 and count<QDEPTH. imem_addr=fpc.
  - Issue decision is registered, so the earliest request is the first cycle after reset release.
  - While outstanding=1, imem_req=1 and imem_addr are held constant until imem_ack.
  - At most one request is in flight.
- Acknowledge: on imem_ack with drop=0, {imem_rdata, fpc} is pushed, fpc<=fpc+4 and outstanding<=0.
- Latency and throughput:
  - An ack in cycle N gives instr_valid=1 in cycle N+1.
  - With zero-wait memory (ack in the same cycle as req) and stall=0, sustained throughput is 1 instruction/cycle.
- Dequeue: when instr_valid=1 and stall=0 at a clock edge, the head is popped. Push and pop in the same cycle leave count unchanged.
- Full queue: no new request is issued. An in-flight request always has a reserved slot (issue requires count<QDEPTH with outstanding=0), so overflow cannot occur.
- Redirect (pc_src=1 at a clock edge):
  - Queue flushed to empty.
  - fpc<=pc_target with bits [1:0] forced to 0.
  - If outstanding=1 and imem_ack=0: drop<=1. The pending response is discarded when acked, and imem_addr stays at the old address until then (no cancel).
  - If imem_ack=1 in the same cycle: that data is discarded and fpc<=pc_target, not +4.
  - pc_src has priority over stall and over push/pop.
- Drop: an ack with drop=1 pushes nothing, clears drop and outstanding, and leaves fpc untouched.
- fpc wrap-around: 32'hFFFF_FFFC+4 = 0; no flag.
- Reset mid-handshake: all state cleared immediately. imem_req drops asynchronously and any later ack is ignored (outstanding=0).

Decomposition:
- Shared package holds:
  - instruction field LSB/MSB constants for COND, OP, FUNCT and RD;
  - the word size constant 4;
  - the PC read offset 8.
- One sub-module, inst_queue:
  - QDEPTH-entry synchronous FIFO of {pc, instr};
  - push/pop/flush inputs; count, empty and full outputs;
  - head read combinationally.

Test Plan:
- Reset release, zero-wait memory, stall=0 → imem_addr sequence 0,4,8,… one per cycle. instr_valid rises 2 cycles after release; pc_plus8=instr_pc+8.
- imem_rdata=32'hE0821003 acked → cond=4'hE, op=2'b00, funct=6'b001000, rd=4'h1.
- stall=1 for 5 cycles → at most QDEPTH pushes, then imem_req=0. The held head is unchanged; after release the order is preserved with no gaps or duplicates.
- Ack delayed 3 cycles → imem_addr stable throughout; one push on ack.
- pc_src=1, pc_target=32'h100 while a request to 32'h8 is pending → queue empties and the 32'h8 response is dropped. The next request goes to 32'h100, then 32'h104.
- pc_src=1, pc_target=32'h203 with a simultaneous ack → acked data discarded; next request address is 32'h200.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared constants and types for the fetch stage: instruction field positions,
// PC arithmetic constants and the queue entry layout.
package fetch_unit_pkg;

  localparam int COND_MSB  = 31;
  localparam int COND_LSB  = 28;
  localparam int OP_MSB    = 27;
  localparam int OP_LSB    = 26;
  localparam int FUNCT_MSB = 25;
  localparam int FUNCT_LSB = 20;
  localparam int RD_MSB    = 15;
  localparam int RD_LSB    = 12;

  localparam logic [31:0] WORD_BYTES  = 32'd4;
  localparam logic [31:0] PC_READ_OFS = 32'd8;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } qentry_t;

  function automatic logic [31:0] align_word(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_inst_queue.sv
// In-order instruction queue of {pc, instr}; the head is read combinationally.
// The owner guarantees no push when full and no pop when empty.
module inst_queue
  import fetch_unit_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic          i_flush,
  input  qentry_t       i_data,
  output qentry_t       o_head,
  output logic [CW-1:0] o_count,
  output logic          o_empty,
  output logic          o_full
);

  qentry_t       r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Storage, pointers and occupancy; flush only rewinds the bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= next_ptr(r_wr_ptr);
      end
      if (i_pop) r_rd_ptr <= next_ptr(r_rd_ptr);
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, runs a single-outstanding imem
// handshake, queues returned words and presents the pre-split head to control.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        pc_src,
  input  logic [31:0] pc_target,
  input  logic        stall,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] pc_plus8,
  output logic [1:0]  op,
  output logic [3:0]  cond,
  output logic [5:0]  funct,
  output logic [3:0]  rd
);

  localparam int CW = $clog2(QDEPTH + 1);

  logic [31:0]   r_fpc;
  logic [31:0]   r_addr;
  logic          r_req;
  logic          r_drop;

  logic          w_ack;
  logic          w_push;
  logic          w_pop;
  logic          w_issue;
  logic          w_out_next;
  logic          w_drop_next;
  logic [31:0]   w_fpc_next;
  logic [CW-1:0] w_count;
  logic [CW-1:0] w_count_next;
  logic          w_empty;
  logic          w_full;
  logic          w_valid;
  qentry_t       w_head;
  qentry_t       w_push_data;

  assign w_valid     = !w_empty;
  assign w_push_data = '{pc: r_fpc, instr: imem_rdata};

  // Next-state for the handshake; a redirect overrides push, pop and stall.
  always_comb begin
    w_ack        = r_req & imem_ack;
    w_push       = !pc_src & w_ack & !r_drop;
    w_pop        = !pc_src & w_valid & !stall;
    w_out_next   = r_req & !imem_ack;
    w_count_next = '0;
    w_fpc_next   = r_fpc;
    w_drop_next  = r_drop;
    if (pc_src) begin
      w_count_next = '0;
      w_fpc_next   = align_word(pc_target);
    end else begin
      w_count_next = w_count + CW'(w_push) - CW'(w_pop);
      w_fpc_next   = w_push ? (r_fpc + WORD_BYTES) : r_fpc;
    end
    // A pending response cannot be cancelled, so it is marked for discard instead.
    if (w_ack) begin
      w_drop_next = 1'b0;
    end else if (pc_src && r_req) begin
      w_drop_next = 1'b1;
    end else begin
      w_drop_next = r_drop;
    end
    w_issue = !w_out_next && (w_count_next < CW'(QDEPTH));
  end

  // Fetch PC, request and drop registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fpc  <= RESET_PC;
      r_addr <= RESET_PC;
      r_req  <= 1'b0;
      r_drop <= 1'b0;
    end else begin
      r_fpc  <= w_fpc_next;
      r_req  <= w_out_next | w_issue;
      r_drop <= w_drop_next;
      if (w_issue) r_addr <= w_fpc_next;
      else         r_addr <= r_addr;
    end
  end

  inst_queue #(.DEPTH(QDEPTH)) u_queue (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (pc_src),
    .i_data  (w_push_data),
    .o_head  (w_head),
    .o_count (w_count),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  assign imem_req    = r_req;
  assign imem_addr   = r_addr;
  assign instr_valid = w_valid;
  assign instr       = w_valid ? w_head.instr : 32'd0;
  assign instr_pc    = w_valid ? w_head.pc : 32'd0;
  assign pc_plus8    = w_valid ? (w_head.pc + PC_READ_OFS) : 32'd0;
  assign cond        = instr[COND_MSB:COND_LSB];
  assign op          = instr[OP_MSB:OP_LSB];
  assign funct       = instr[FUNCT_MSB:FUNCT_LSB];
  assign rd          = instr[RD_MSB:RD_LSB];

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a memory model with programmable latency
// and a scoreboard of expected {pc, word} pairs compared at the queue head.
module tb_fetch_unit;

  localparam int QDEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        pc_src;
  logic [31:0] pc_target;
  logic        stall;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] pc_plus8;
  logic [1:0]  op;
  logic [3:0]  cond;
  logic [5:0]  funct;
  logic [3:0]  rd;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000), .QDEPTH(QDEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .pc_src(pc_src),
    .pc_target(pc_target), .stall(stall), .instr_valid(instr_valid),
    .instr(instr), .instr_pc(instr_pc), .pc_plus8(pc_plus8), .op(op),
    .cond(cond), .funct(funct), .rd(rd)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] m_fpc;
  bit          m_drop;
  int          lat;
  int          wait_cnt;
  bit          prev_pend;
  logic [31:0] prev_addr;
  int          n_acks;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0010) return 32'hE082_1003;
    return {a[15:0] ^ 16'h5A5A, a[31:16] ^ 16'hC3C3};
  endfunction

  task automatic model_reset();
    sb.delete();
    m_fpc     = 32'h0;
    m_drop    = 1'b0;
    wait_cnt  = 0;
    prev_pend = 1'b0;
    prev_addr = 32'h0;
  endtask

  // One clock: drive inputs after the edge, check at negedge, advance the model.
  task automatic cycle(input bit src, input logic [31:0] tgt, input bit stl);
    exp_t e;
    @(posedge clk); #1;
    pc_src    = src;
    pc_target = tgt;
    stall     = stl;
    if (imem_req && wait_cnt >= lat) begin
      imem_ack   = 1'b1;
      imem_rdata = mem_word(imem_addr);
    end else begin
      imem_ack   = 1'b0;
      imem_rdata = 32'hDEAD_BEEF;
      if (imem_req) wait_cnt++;
    end
    @(negedge clk);
    if (prev_pend) begin
      chk("req_held", 32'(imem_req), 32'd1);
      chk("addr_held", imem_addr, prev_addr);
    end
    if (imem_req && !m_drop) chk("fetch_addr", imem_addr, m_fpc);
    chk("valid", 32'(instr_valid), 32'(sb.size() != 0));
    if (sb.size() != 0) begin
      e = sb[0];
      chk("instr", instr, e.word);
      chk("instr_pc", instr_pc, e.pc);
      chk("pc_plus8", pc_plus8, e.pc + 32'd8);
      chk("cond", 32'(cond), 32'(e.word[31:28]));
      chk("op", 32'(op), 32'(e.word[27:26]));
      chk("funct", 32'(funct), 32'(e.word[25:20]));
      chk("rd", 32'(rd), 32'(e.word[15:12]));
      if (e.word == 32'hE082_1003) begin
        chk("cond_k", 32'(cond), 32'hE);
        chk("op_k", 32'(op), 32'h0);
        chk("funct_k", 32'(funct), 32'h08);
        chk("rd_k", 32'(rd), 32'h1);
      end
    end else begin
      chk("idle_instr", instr, 32'h0);
      chk("idle_pc", instr_pc, 32'h0);
      chk("idle_pc8", pc_plus8, 32'h0);
      chk("idle_fields", {18'd0, cond, op, funct, rd}, 32'h0);
    end
    prev_pend = imem_req && !imem_ack;
    prev_addr = imem_addr;
    if (imem_ack) begin
      wait_cnt = 0;
      n_acks++;
    end
    if (src) begin
      sb.delete();
      m_drop = imem_req && !imem_ack ? 1'b1 : 1'b0;
      m_fpc  = {tgt[31:2], 2'b00};
    end else begin
      if (sb.size() != 0 && !stl) sb.delete(0);
      if (imem_ack) begin
        if (m_drop) begin
          m_drop = 1'b0;
        end else begin
          e.pc   = m_fpc;
          e.word = mem_word(m_fpc);
          sb.push_back(e);
          m_fpc  = m_fpc + 32'd4;
        end
      end
    end
  endtask

  initial begin
    int a0;
    bit found;
    pc_src = 1'b0; pc_target = 32'h0; stall = 1'b0;
    imem_ack = 1'b0; imem_rdata = 32'h0; lat = 0; n_acks = 0;
    model_reset();

    #12;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_outs", instr | instr_pc | pc_plus8, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Zero-wait streaming from reset.
    a0 = n_acks;
    cycle(1'b0, 32'h0, 1'b0);
    chk("first_req", 32'(imem_req), 32'd1);
    chk("first_valid", 32'(instr_valid), 32'd0);
    cycle(1'b0, 32'h0, 1'b0);
    chk("second_valid", 32'(instr_valid), 32'd1);
    repeat (10) cycle(1'b0, 32'h0, 1'b0);
    chk("throughput", 32'(n_acks - a0), 32'd12);

    // Back-pressure fills the queue and halts requests.
    repeat (5) cycle(1'b0, 32'h0, 1'b1);
    chk("full_noreq", 32'(imem_req), 32'd0);
    chk("full_count", 32'(sb.size()), 32'(QDEPTH));
    repeat (6) cycle(1'b0, 32'h0, 1'b0);

    // Slow memory.
    lat = 3;
    repeat (14) cycle(1'b0, 32'h0, 1'b0);

    // Redirect while the request to 0x8 is pending.
    cycle(1'b1, 32'h0, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      cycle(1'b0, 32'h0, 1'b0);
      if (imem_req && !imem_ack && !m_drop && m_fpc == 32'h8) found = 1'b1;
    end
    chk("pend8_seen", 32'(found), 32'd1);
    cycle(1'b1, 32'h100, 1'b0);
    cycle(1'b0, 32'h0, 1'b0);
    chk("drop_addr", imem_addr, 32'h8);
    chk("flush_empty", 32'(instr_valid), 32'd0);
    repeat (16) cycle(1'b0, 32'h0, 1'b0);

    // Redirect coinciding with an ack.
    lat = 0;
    repeat (4) cycle(1'b0, 32'h0, 1'b0);
    cycle(1'b1, 32'h203, 1'b0);
    chk("sim_ack", 32'(imem_ack), 32'd1);
    cycle(1'b0, 32'h0, 1'b0);
    chk("redir_addr", imem_addr, 32'h200);
    repeat (4) cycle(1'b0, 32'h0, 1'b0);

    // Fetch PC wrap-around.
    cycle(1'b1, 32'hFFFF_FFF8, 1'b0);
    repeat (8) cycle(1'b0, 32'h0, 1'b0);

    // Random mix of latency, stall and redirects.
    for (int i = 0; i < 300; i++) begin
      if (i % 16 == 0) lat = $urandom_range(0, 2);
      cycle(($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0, $urandom,
            ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0);
    end

    // Reset in the middle of a handshake.
    lat = 4;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      cycle(1'b0, 32'h0, 1'b0);
      if (imem_req && !imem_ack) found = 1'b1;
    end
    chk("pend_seen", 32'(found), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_req", 32'(imem_req), 32'd0);
    chk("async_valid", 32'(instr_valid), 32'd0);
    chk("async_addr", imem_addr, 32'h0);
    imem_ack = 1'b0;
    pc_src = 1'b0;
    stall = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    lat = 0;
    repeat (8) cycle(1'b0, 32'h0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
